// File: rtl/ov7670_reg_sequencer.sv
// Table-driven SCCB register sequencer: walks {addr,data} entries, one SCCB write per entry.
// Optional feature macro CFG_RETRY_EN: failed writes are retried up to MAX_RETRY extra times.
module ov7670_reg_sequencer #(
  parameter int unsigned NUM_REGS       = 64,
  parameter int unsigned IDX_W          = 6,
  parameter int unsigned DELAY_UNIT     = 1024,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned AUTO_START     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [15:0]      tbl_entry,
  output logic             sccb_start,
  output logic [7:0]       sccb_addr,
  output logic [7:0]       sccb_data,
  input  logic             sccb_done,
  input  logic             sccb_nack,
  output logic             busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [IDX_W-1:0] err_idx
);

`ifdef CFG_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam logic [31:0]      SETTLE_LOAD  = (SETTLE_CYCLES == 0) ? 32'd0 : 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_SETTLE, S_DELAY, S_RETRY, S_DONE, S_ERROR
  } state_t;

  state_t           state, state_n;
  logic [31:0]      cnt, cnt_n;
  logic [IDX_W-1:0] idx_n, err_idx_n;
  logic [7:0]       addr_n, data_n;
  logic [7:0]       retry_cnt, retry_n;
  logic             done_n, err_n;
  logic             pend, pend_n;
  logic             fail, step;
  logic [31:0]      delay_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tbl_idx   <= '0;
      sccb_addr <= '0;
      sccb_data <= '0;
      retry_cnt <= '0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      err_idx   <= '0;
      pend      <= (AUTO_START != 0);
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tbl_idx   <= idx_n;
      sccb_addr <= addr_n;
      sccb_data <= data_n;
      retry_cnt <= retry_n;
      cfg_done  <= done_n;
      cfg_err   <= err_n;
      err_idx   <= err_idx_n;
      pend      <= pend_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = tbl_idx;
    addr_n    = sccb_addr;
    data_n    = sccb_data;
    retry_n   = retry_cnt;
    done_n    = cfg_done;
    err_n     = cfg_err;
    err_idx_n = err_idx;
    pend_n    = pend;
    fail      = 1'b0;
    step      = 1'b0;
    delay_len = 32'(tbl_entry[7:0]) * DELAY_UNIT;

    case (state)
      S_IDLE: begin
        // pend carries the post-reset auto start and restarts requested from DONE/ERROR
        if (start || pend) begin
          pend_n  = 1'b0;
          done_n  = 1'b0;
          err_n   = 1'b0;
          idx_n   = '0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        retry_n = '0;
        if (tbl_entry == 16'hFFFF) begin
          done_n  = 1'b1;
          state_n = S_DONE;
        end else if (tbl_entry[15:8] == 8'hF0) begin
          cnt_n   = (tbl_entry[7:0] == 8'd0) ? 32'd0 : delay_len - 32'd1;
          state_n = S_DELAY;
        end else begin
          addr_n  = tbl_entry[15:8];
          data_n  = tbl_entry[7:0];
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a timeout landing in the same cycle
        if (sccb_done) begin
          if (sccb_nack) begin
            fail = 1'b1;
          end else begin
            cnt_n   = SETTLE_LOAD;
            state_n = S_SETTLE;
          end
        end else if (TIMEOUT_CYCLES != 0 && cnt == TIMEOUT_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_SETTLE, S_DELAY: begin
        if (cnt == '0) step = 1'b1;
        else           cnt_n = cnt - 32'd1;
      end
      S_RETRY: begin
        if (cnt == '0) state_n = S_ISSUE;
        else           cnt_n = cnt - 32'd1;
      end
      S_DONE, S_ERROR: begin
        if (start) begin
          pend_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (step) begin
      if (tbl_idx == LAST_IDX) begin
        done_n  = 1'b1;
        state_n = S_DONE;
      end else begin
        idx_n   = tbl_idx + IDX_W'(1);
        state_n = S_FETCH;
      end
    end

    if (fail) begin
      if (RETRY_EN && (32'(retry_cnt) < MAX_RETRY)) begin
        retry_n = retry_cnt + 8'd1;
        cnt_n   = SETTLE_LOAD;
        state_n = S_RETRY;
      end else begin
        err_n     = 1'b1;
        err_idx_n = tbl_idx;
        state_n   = S_ERROR;
      end
    end
  end

  assign sccb_start = (state == S_ISSUE);
  assign busy       = !(state inside {S_IDLE, S_DONE, S_ERROR});

endmodule

// File: tb/tb_ov7670_reg_sequencer.sv
// Bench for ov7670_reg_sequencer: directed vector table, reset/restart sequences and random
// tables scored against a cycle-arithmetic model of the table walk.
module tb_ov7670_reg_sequencer;
  localparam int NREG = 16;
  localparam int IW   = 4;
  localparam int DU   = 8;
  localparam int SET  = 4;
  localparam int TO   = 100;
  localparam int MAXR = 3;
`ifdef CFG_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start;
  logic [IW-1:0] tbl_idx, err_idx;
  logic [15:0]   tbl_entry;
  logic          sccb_start, sccb_done, sccb_nack, busy, cfg_done, cfg_err;
  logic [7:0]    sccb_addr, sccb_data;

  ov7670_reg_sequencer #(
    .NUM_REGS(NREG), .IDX_W(IW), .DELAY_UNIT(DU), .SETTLE_CYCLES(SET),
    .TIMEOUT_CYCLES(TO), .MAX_RETRY(MAXR), .AUTO_START(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tbl_idx(tbl_idx), .tbl_entry(tbl_entry),
    .sccb_start(sccb_start), .sccb_addr(sccb_addr), .sccb_data(sccb_data),
    .sccb_done(sccb_done), .sccb_nack(sccb_nack), .busy(busy), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] rom [NREG];
  int          nack_cnt [NREG];
  bit          hang [NREG];
  int          att [NREG];
  int          lat = 2;
  assign tbl_entry = rom[tbl_idx];

  typedef struct { int cy; logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t got_q[$];
  wr_t exp_q[$];
  int  exp_n, exp_end, exp_idx;
  bit  exp_done, use_q;

  always @(negedge clk) if (sccb_start) got_q.push_back('{cyc, sccb_addr, sccb_data});

  // SCCB slave: answers lat cycles after a request, NACKing the first nack_cnt attempts per entry
  int rsp_cnt = 0;
  bit rsp_nack = 1'b0;
  initial begin
    sccb_done = 1'b0;
    sccb_nack = 1'b0;
    forever begin
      @(negedge clk);
      sccb_done = 1'b0;
      sccb_nack = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          sccb_done = 1'b1;
          sccb_nack = rsp_nack;
        end
      end
      if (sccb_start) begin
        int i;
        i = int'(tbl_idx);
        if (!hang[i]) begin
          rsp_nack = (att[i] < nack_cnt[i]);
          rsp_cnt  = lat;
        end
        att[i]++;
      end
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic longint pk(input int off, input logic [7:0] a, input logic [7:0] d);
    return (longint'(off) << 16) | (longint'(a) << 8) | longint'(d);
  endfunction

  task automatic chk_zero(input string name);
    chk(name, {tbl_idx, sccb_start, sccb_addr, sccb_data, busy, cfg_done, cfg_err, err_idx}, 0);
  endtask

  task automatic clear_tables();
    for (int i = 0; i < NREG; i++) begin
      rom[i] = 16'hFFFF;
      nack_cnt[i] = 0;
      hang[i] = 1'b0;
    end
  endtask

  // Cycle arithmetic per entry, offsets relative to the first FETCH cycle
  function automatic void model();
    int t, idx, c, x, a, nxt;
    logic [15:0] e;
    bit fin;
    exp_q.delete();
    t = 0; idx = 0; fin = 1'b0; use_q = 1'b1;
    exp_idx = 0; exp_done = 1'b0; exp_end = 0;
    while (!fin) begin
      e = rom[idx];
      nxt = -1;
      if (e == 16'hFFFF) begin
        exp_done = 1'b1; exp_end = t + 1; fin = 1'b1;
      end else if (e[15:8] == 8'hF0) begin
        nxt = t + 1 + ((e[7:0] == 8'd0) ? 1 : int'(e[7:0]) * DU);
      end else begin
        c = t + 1; a = 0;
        while (nxt < 0 && !fin) begin
          exp_q.push_back('{c, e[15:8], e[7:0]});
          x = hang[idx] ? c + TO : c + lat;
          if (!hang[idx] && a >= nack_cnt[idx]) nxt = x + 1 + SET;
          else if (RETRY && a < MAXR) begin c = x + 1 + SET; a++; end
          else begin exp_done = 1'b0; exp_idx = idx; exp_end = x + 1; fin = 1'b1; end
        end
      end
      if (!fin) begin
        if (idx == NREG - 1) begin exp_done = 1'b1; exp_end = nxt; fin = 1'b1; end
        else begin idx++; t = nxt; end
      end
    end
    exp_n = exp_q.size();
  endfunction

  task automatic gen_table(input bit no_end);
    int hangs;
    hangs = 0;
    clear_tables();
    for (int i = 0; i < NREG; i++) begin
      int r;
      logic [7:0] ad;
      r  = $urandom_range(0, 99);
      ad = 8'($urandom_range(0, 255));
      if (ad == 8'hF0 || ad == 8'hFF) ad = 8'h3A;
      if (r < 8 && !no_end) rom[i] = 16'hFFFF;
      else if (r < 22)      rom[i] = {8'hF0, 8'($urandom_range(0, 4))};
      else                  rom[i] = {ad, 8'($urandom)};
      if ($urandom_range(0, 9) < 2) nack_cnt[i] = $urandom_range(1, 4);
      if (hangs == 0 && $urandom_range(0, 29) == 0) begin hang[i] = 1'b1; hangs++; end
    end
  endtask

  // Pulses start while the DUT sits in DONE/ERROR; first FETCH follows two cycles later
  task automatic launch(output int f);
    for (int i = 0; i < NREG; i++) att[i] = 0;
    got_q.delete();
    @(negedge clk);
    start = 1'b1;
    f = cyc + 2;
  endtask

  task automatic check_run(input int f, input int poke, input string tag);
    int endc;
    endc = -1;
    for (int k = 0; k < 3000 && endc < 0; k++) begin
      @(negedge clk);
      start = (poke > 0 && cyc == f + poke);
      if (cyc >= f && (cfg_done || cfg_err)) endc = cyc - f;
    end
    start = 1'b0;
    chk({tag, ".end_cycle"}, endc, exp_end);
    chk({tag, ".outcome"}, {cfg_done, cfg_err}, exp_done ? 2 : 1);
    if (!exp_done) chk({tag, ".err_idx"}, err_idx, exp_idx);
    chk({tag, ".busy"}, busy, 0);
    repeat (3) @(negedge clk);
    chk({tag, ".n_writes"}, got_q.size(), exp_n);
    if (use_q)
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        chk($sformatf("%s.write%0d", tag, i), pk(got_q[i].cy - f, got_q[i].a, got_q[i].d),
            pk(exp_q[i].cy, exp_q[i].a, exp_q[i].d));
  endtask

  typedef struct {
    logic [15:0] e0, e1, e2;
    int fidx, nack;
    bit hng;
    int n;
    bit dn;
    int eidx, cy;
  } vec_t;
  vec_t vt [10];

  initial begin
    int f;
    vt[0] = '{16'h1280, 16'h1204, 16'hFFFF, 0, 0, 0, 2, 1'b1, 0, 17};
    vt[1] = '{16'hF002, 16'h1234, 16'hFFFF, 0, 0, 0, 1, 1'b1, 0, 26};
    vt[2] = '{16'hF000, 16'h1234, 16'hFFFF, 0, 0, 0, 1, 1'b1, 0, 11};
    vt[3] = '{16'hFFFF, 16'h1234, 16'hFFFF, 0, 0, 0, 0, 1'b1, 0, 1};
    vt[4] = '{16'hF001, 16'hF003, 16'hFFFF, 0, 0, 0, 0, 1'b1, 0, 35};
    vt[5] = '{16'h8C02, 16'h40D0, 16'hFFFF, 0, 1, 0, RETRY ? 3 : 1, RETRY, 0, RETRY ? 24 : 4};
    vt[6] = '{16'h1280, 16'h8C02, 16'hFFFF, 1, 0, 1, RETRY ? 5 : 2, 1'b0, 1, RETRY ? 425 : 110};
    vt[7] = '{16'h1280, 16'hFFFF, 16'hFFFF, 0, 2, 0, RETRY ? 3 : 1, RETRY, 0, RETRY ? 23 : 4};
    vt[8] = '{16'h1280, 16'hFFFF, 16'hFFFF, 0, 4, 0, RETRY ? 4 : 1, 1'b0, 0, RETRY ? 25 : 4};
    vt[9] = '{16'h1280, 16'h1204, 16'h8C02, 2, 1, 0, RETRY ? 4 : 3, RETRY, 2, RETRY ? 32 : 20};

    rst = 1'b1;
    start = 1'b0;
    clear_tables();
    rom[0] = 16'h1280; rom[1] = 16'h1204; rom[2] = 16'h8C02; rom[3] = 16'h40D0;
    lat = 2;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    model();
    rst = 1'b0;
    f = cyc + 1;
    check_run(f, 0, "auto_start");

    for (int v = 0; v < 10; v++) begin
      clear_tables();
      rom[0] = vt[v].e0; rom[1] = vt[v].e1; rom[2] = vt[v].e2;
      nack_cnt[vt[v].fidx] = vt[v].nack;
      hang[vt[v].fidx] = vt[v].hng;
      lat = 2;
      exp_q.delete();
      use_q = 1'b0;
      exp_n = vt[v].n; exp_done = vt[v].dn; exp_idx = vt[v].eidx; exp_end = vt[v].cy;
      launch(f);
      check_run(f, 0, $sformatf("vec%0d", v));
    end

    for (int s = 0; s < 20; s++) begin
      gen_table(s >= 18);
      lat = $urandom_range(1, 4);
      model();
      launch(f);
      check_run(f, (exp_end > 12) ? 6 : 0, $sformatf("rnd%0d", s));
    end

    // reset while waiting on the SCCB master; its late done lands in IDLE
    clear_tables();
    rom[0] = 16'h1280;
    lat = 2;
    launch(f);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pre.busy", busy, 1);
    chk("rst_pre.n_writes", got_q.size(), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid_wait");
    got_q.delete();
    rst = 1'b0;
    model();
    check_run(f + 4, 0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
